piece_queue_gen: RTL
====================

// Module: piece_queue_gen
// PURPOSE
//  Parametrised next-piece generator for the Tetris core, replacing the fixed 1..7 counter sampler.
//  - A free-running Galois LFSR feeds a 7-bag shuffler: every piece appears once per bag.
//  - Results go through a preview FIFO: the head drives the spawner, and the next PREVIEW_DEPTH
//    pieces drive the "next" display.
//  - Sits between the game FSM (drop requests) and the spawn/render logic.
// PARAMETERS
//  NUM_PIECES     7        distinct piece IDs, encoded 1..NUM_PIECES; 0 = no piece (2..15)
//  PIECE_W        4        piece ID width
//  PREVIEW_DEPTH  3        visible upcoming pieces; queue holds PREVIEW_DEPTH+1 entries
//  LFSR_W         16       LFSR width
//  SEED           16'hACE1 reset seed; a zero seed is always replaced by SEED
// PORTS
//  clk            in   1                        system clock, single clock domain
//  rst            in   1                        reset: synchronous, active-low
//  drop           in   1                        1-cycle pulse: consume head piece
//  seed_load      in   1                        load seed_in and restart generation
//  seed_in        in   LFSR_W                   new seed value
//  piece_out      out  PIECE_W                  queue head (current piece), 0 when invalid
//  piece_valid    out  1                        head holds a valid piece
//  preview        out  PREVIEW_DEPTH*PIECE_W    entry k at [k*PIECE_W +: PIECE_W], k=0 soonest
//  preview_valid  out  1                        all preview entries valid
//  drop_miss      out  1                        1-cycle pulse: drop while !piece_valid
//  bag_left       out  4                        unused pieces remaining in current bag
// BEHAVIOUR
//  Reset (rst==0 at posedge):
//   - LFSR=SEED, bag mask cleared, queue cleared, count=0, state=FILL.
//   - Outputs: piece_out=0, preview=0, piece_valid=0, preview_valid=0, drop_miss=0,
//     bag_left=NUM_PIECES.
//  LFSR: advances every cycle, including idle cycles; the player's timing supplies the entropy.
//  Draw (at most one per cycle, while count < PREVIEW_DEPTH+1):
//   - off = LFSR[7:0] mod NUM_PIECES.
//   - Pick the first unused ID scanning cyclically from off; mark it used and append it at the tail.
//   - When the last unused ID is drawn, the bag mask clears in the same cycle.
//  States:
//   - FILL: draw every cycle. Enter READY when count reaches PREVIEW_DEPTH+1.
//   - READY: queue full. On a valid drop, go to REFILL.
//   - REFILL: draw one piece, return to READY.
//  Queue timing:
//   - Each draw is registered. piece_valid rises on the 2nd posedge after reset release.
//   - preview_valid rises PREVIEW_DEPTH cycles later.
//  Drop:
//   - Valid drop at posedge N: head shifts out; piece_out shows the old preview[0] after N.
//   - Refill draw lands at posedge N+1. A drop during REFILL is allowed: shift and append
//     happen in the same cycle, count unchanged.
//   - A drop while piece_valid=0 is ignored and drop_miss pulses 1 cycle.
//  seed_load:
//   - Highest priority after reset; a coincident drop is ignored.
//   - Loads seed_in (SEED if seed_in==0), clears bag and queue, state=FILL, outputs as reset.
//  Widths: preview entries beyond count read 0. bag_left = NUM_PIECES - popcount(mask).
// CONFIGURATION
//  PIECE_BAG_EN defined:
//   - 7-bag shuffler as above.
//   - Any NUM_PIECES consecutive draws aligned to a bag boundary contain every ID exactly once.
//  PIECE_BAG_EN undefined:
//   - Bag mask removed; draw = off+1, so repeats are allowed.
//   - bag_left is tied to NUM_PIECES. All timing is identical.
// STRUCTURE
//  - Shared header global.v: piece ID constants (PIECE_NONE=0, I..Z), FSM state encodings,
//    LFSR tap constant per width.
//  - Sub-module lfsr_core (WIDTH, TAPS, SEED):
//    - inputs load, load_val; output state.
//    - Zero-lock guard inside lfsr_core.
//  - Bag scan, queue shift register and FSM live in piece_queue_gen.
// TESTING
//  1. Reset, no drop:
//     - piece_valid=1 at posedge 2 after release.
//     - preview_valid=1 at posedge 5 (depth 3).
//     - bag_left=3 once 4 pieces are drawn.
//  2. PIECE_BAG_EN, 70 drops spaced 3 cycles:
//     - each aligned group of 7 heads is a permutation of 1..7.
//     - no ID ever outside 1..7.
//  3. Drops on consecutive cycles:
//     - piece_out follows old preview[0] each cycle; count stays 4.
//     - no drop_miss; no invalid head.
//  4. drop asserted 1 cycle after reset release (piece_valid=0):
//     - drop_miss=1 for 1 cycle; queue contents unaffected.
//  5. seed_load with seed_in=0x1234, twice with identical later stimulus:
//     - identical piece sequences.
//     - seed_in=0 behaves exactly as 0xACE1.
//  6. PIECE_BAG_EN undefined, 1000 drops:
//     - all IDs in 1..7; at least one immediate repeat observed.
//     - bag_left constant at 7.

Source files
------------

// File: rtl/piece_queue_gen_pkg.sv
// Shared types and constants for the next-piece generator: piece IDs,
// FSM state encoding and Galois LFSR tap masks per register width.
package piece_queue_gen_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_READY  = 2'd1,
    ST_REFILL = 2'd2
  } state_e;

  localparam logic [3:0] PIECE_NONE = 4'd0;
  localparam logic [3:0] PIECE_I    = 4'd1;
  localparam logic [3:0] PIECE_O    = 4'd2;
  localparam logic [3:0] PIECE_T    = 4'd3;
  localparam logic [3:0] PIECE_J    = 4'd4;
  localparam logic [3:0] PIECE_L    = 4'd5;
  localparam logic [3:0] PIECE_S    = 4'd6;
  localparam logic [3:0] PIECE_Z    = 4'd7;

  // Right-shifting Galois masks for maximal-length polynomials.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       return 32'h0000_00B8;
      12:      return 32'h0000_0E08;
      16:      return 32'h0000_B400;
      20:      return 32'h0009_0000;
      24:      return 32'h00E1_0000;
      32:      return 32'hA300_0000;
      default: return 32'h0000_B400;
    endcase
  endfunction

endpackage

// File: rtl/piece_queue_gen_lfsr_core.sv
// Free-running right-shift Galois LFSR with seed load; an all-zero value
// (loaded or reached) is always replaced by SEED so the register never locks.
module lfsr_core
  import piece_queue_gen_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'hACE1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] step;

  always_comb begin
    step = state_q >> 1;
    if (state_q[0]) step = step ^ TAPS;
    state_d = step;
    if (load) begin
      state_d = (load_val == '0) ? SEED : load_val;
    end else if (state_q == '0) begin
      state_d = SEED;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= SEED;
    else      state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/piece_queue_gen.sv
// Next-piece generator: LFSR-driven draw into a head+preview shift queue.
// Build option PIECE_BAG_EN enables the 7-bag shuffler (no repeats within a bag).
module piece_queue_gen
  import piece_queue_gen_pkg::*;
#(
  parameter int                NUM_PIECES    = 7,
  parameter int                PIECE_W       = 4,
  parameter int                PREVIEW_DEPTH = 3,
  parameter int                LFSR_W        = 16,
  parameter logic [LFSR_W-1:0] SEED          = LFSR_W'(16'hACE1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             drop,
  input  logic                             seed_load,
  input  logic [LFSR_W-1:0]                seed_in,
  output logic [PIECE_W-1:0]               piece_out,
  output logic                             piece_valid,
  output logic [PREVIEW_DEPTH*PIECE_W-1:0] preview,
  output logic                             preview_valid,
  output logic                             drop_miss,
  output logic [3:0]                       bag_left,
  output state_e                           dbg_state
);

  localparam int               Q_N   = PREVIEW_DEPTH + 1;
  localparam int               CNT_W = $clog2(Q_N + 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(Q_N);
  localparam logic [7:0]       NP8   = 8'(NUM_PIECES);

  logic [LFSR_W-1:0]  lfsr;
  logic [7:0]         off8;
  logic [PIECE_W-1:0] draw_id;
  logic               unused_lfsr_hi;

  logic [PIECE_W-1:0] q_q [Q_N];
  logic [PIECE_W-1:0] q_d [Q_N];
  logic [CNT_W-1:0]   count_q, count_d, cnt_tmp;
  state_e             state_q, state_d;
  logic               draw_en_q, draw_en_d;
  logic               drop_miss_q, drop_miss_d;
  logic               head_valid, drop_ok, draw_fire;

  lfsr_core #(
    .WIDTH (LFSR_W),
    .TAPS  (LFSR_W'(lfsr_taps(LFSR_W))),
    .SEED  (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (seed_load),
    .load_val (seed_in),
    .state    (lfsr)
  );

  assign off8           = lfsr[7:0] % NP8;
  assign unused_lfsr_hi = ^lfsr[LFSR_W-1:8];

`ifdef PIECE_BAG_EN
  localparam int IDX_W = (NUM_PIECES > 1) ? $clog2(NUM_PIECES) : 1;

  logic [NUM_PIECES-1:0] mask_q, mask_d, mask_set;
  logic [IDX_W-1:0]      draw_idx;
  logic [7:0]            cand;
  logic                  found;
  logic [3:0]            used_cnt;

  // First unused ID scanning cyclically upward from the random offset.
  always_comb begin
    draw_idx = '0;
    found    = 1'b0;
    cand     = '0;
    for (int i = 0; i < NUM_PIECES; i++) begin
      cand = off8 + 8'(i);
      if (cand >= NP8) cand = cand - NP8;
      if (!found && !mask_q[IDX_W'(cand)]) begin
        found    = 1'b1;
        draw_idx = IDX_W'(cand);
      end
    end
    draw_id = PIECE_W'(draw_idx) + PIECE_W'(1);
  end

  // Drawing the last unused ID empties the bag in the same cycle.
  always_comb begin
    mask_set           = mask_q;
    mask_set[draw_idx] = 1'b1;
    mask_d             = mask_q;
    if (draw_fire) mask_d = (&mask_set) ? '0 : mask_set;
    if (seed_load) mask_d = '0;
  end

  always_comb begin
    used_cnt = '0;
    for (int i = 0; i < NUM_PIECES; i++) used_cnt = used_cnt + 4'(mask_q[i]);
  end

  assign bag_left = 4'(NUM_PIECES) - used_cnt;

  always_ff @(posedge clk) begin
    if (!rst) mask_q <= '0;
    else      mask_q <= mask_d;
  end
`else
  assign draw_id  = PIECE_W'(off8) + PIECE_W'(1);
  assign bag_left = 4'(NUM_PIECES);
`endif

  // draw_en_q holds off drawing for the first cycle after (re)start.
  always_comb begin
    head_valid  = (count_q != '0);
    drop_ok     = drop && head_valid;
    draw_fire   = draw_en_q && (state_q != ST_READY) && (count_q < FULL);
    q_d         = q_q;
    cnt_tmp     = count_q;
    state_d     = state_q;
    draw_en_d   = 1'b1;
    drop_miss_d = drop && !head_valid;

    if (drop_ok) begin
      for (int k = 0; k < Q_N - 1; k++) q_d[k] = q_q[k+1];
      q_d[Q_N-1] = '0;
      cnt_tmp    = cnt_tmp - CNT_W'(1);
    end
    if (draw_fire) begin
      for (int k = 0; k < Q_N; k++) begin
        if (CNT_W'(k) == cnt_tmp) q_d[k] = draw_id;
      end
      cnt_tmp = cnt_tmp + CNT_W'(1);
    end
    count_d = cnt_tmp;

    case (state_q)
      ST_FILL, ST_REFILL: if (count_d == FULL) state_d = ST_READY;
      ST_READY:           if (drop_ok) state_d = ST_REFILL;
      default:            state_d = ST_FILL;
    endcase

    if (seed_load) begin
      for (int k = 0; k < Q_N; k++) q_d[k] = '0;
      count_d     = '0;
      state_d     = ST_FILL;
      draw_en_d   = 1'b0;
      drop_miss_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < Q_N; k++) q_q[k] <= '0;
      count_q     <= '0;
      state_q     <= ST_FILL;
      draw_en_q   <= 1'b0;
      drop_miss_q <= 1'b0;
    end else begin
      q_q         <= q_d;
      count_q     <= count_d;
      state_q     <= state_d;
      draw_en_q   <= draw_en_d;
      drop_miss_q <= drop_miss_d;
    end
  end

  always_comb begin
    preview = '0;
    for (int k = 0; k < PREVIEW_DEPTH; k++) preview[k*PIECE_W +: PIECE_W] = q_q[k+1];
  end

  assign piece_out     = q_q[0];
  assign piece_valid   = head_valid;
  assign preview_valid = (count_q == FULL);
  assign drop_miss     = drop_miss_q;
  assign dbg_state     = state_q;

endmodule
